// File: rtl/sequence_presenter.sv
// sequence_presenter
// Walks a 16x4 sequence ROM from entry 0 up to a captured limit, showing each
// entry on the LEDs for ON_CYCLES clocks. When the macro SHOW_GAP_EN is
// defined, every entry is followed by OFF_CYCLES blank clocks (GAP state);
// otherwise entries follow each other with only the FETCH/LOAD cycles between.
// A one-cycle done pulse marks a completed presentation; abort cancels it.
// ON_CYCLES and OFF_CYCLES must both be at least 1.
module sequence_presenter #(
  parameter int ON_CYCLES  = 1000,
  parameter int OFF_CYCLES = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] limit,
  input  logic [3:0] mem_data,
  output logic [3:0] mem_addr,
  output logic [3:0] leds,
  output logic       busy,
  output logic       done,
  output logic [2:0] db_state
);

  // Counter holds up to max(ON_CYCLES, OFF_CYCLES)-1.
  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
`ifdef SHOW_GAP_EN
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHOW  = 3'd3,
`ifdef SHOW_GAP_EN
    S_GAP   = 3'd4,
`endif
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       addr_q, addr_d;
  logic [3:0]       limit_q, limit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       leds_q, leds_d;
  logic             entry_end;

  // State, address, captured limit, cycle counter and LED register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= 4'd0;
      limit_q <= 4'd0;
      cnt_q   <= '0;
      leds_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      limit_q <= limit_d;
      cnt_q   <= cnt_d;
      leds_q  <= leds_d;
    end
  end

  // Next-state logic: sequencing, entry completion, counter and abort handling.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    limit_d   = limit_q;
    cnt_d     = cnt_q;
    leds_d    = leds_q;
    entry_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort wins over start; limit is frozen for the whole presentation
        if (start && !abort) begin
          addr_d  = 4'd0;
          limit_d = limit;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // ROM samples mem_addr at the end of this cycle
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // ROM data is valid now (1-cycle read latency)
        leds_d  = mem_data;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (cnt_q == ON_LAST) begin
`ifdef SHOW_GAP_EN
          leds_d  = 4'd0;
          state_d = S_GAP;
`else
          entry_end = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef SHOW_GAP_EN
      S_GAP: begin
        if (cnt_q == OFF_LAST) begin
          entry_end = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Last entry finishes the run; otherwise step to the next ROM entry.
    // The address never passes the limit, so it cannot wrap past 15.
    if (entry_end) begin
      if (addr_q == limit_q) begin
        leds_d  = 4'd0;
        state_d = S_DONE;
      end else begin
        addr_d  = addr_q + 4'd1;
        state_d = S_FETCH;
      end
    end

    // Counter restarts at zero on every state entry.
    if (state_d != state_q) begin
      cnt_d = '0;
    end

    // Abort cancels from any active state without a done pulse.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      leds_d  = 4'd0;
      addr_d  = 4'd0;
      cnt_d   = '0;
    end
  end

  assign mem_addr = addr_q;
  assign leds     = leds_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign db_state = state_q;

endmodule

// File: tb/tb_sequence_presenter.sv
// Scoreboard bench for sequence_presenter (ON_CYCLES=4, OFF_CYCLES=2).
// Stimulus pushes expected display events; a monitor reports what the DUT
// shows (entry runs, gap runs, done pulses) and pops/compares.
module tb_sequence_presenter;
  localparam int ON  = 4;
  localparam int OFF = 2;
`ifdef SHOW_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam int PER_ENTRY = 2 + ON + (GAP_EN ? OFF : 0);

  logic       clock;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] limit;
  logic [3:0] mem_data;
  logic [3:0] mem_addr;
  logic [3:0] leds;
  logic       busy;
  logic       done;
  logic [2:0] db_state;

  sequence_presenter #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .limit(limit), .mem_data(mem_data), .mem_addr(mem_addr),
    .leds(leds), .busy(busy), .done(done), .db_state(db_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM: 0001, 0010, 0100, 1000 repeating, 1-cycle read latency
  logic [3:0] rom [16];
  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));
    mem_data = 4'd0;
  end
  always @(posedge clock) mem_data <= rom[mem_addr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // kind 0: lit entry (val=pattern, len=cycles); 1: gap (val=0, len);
  // 2: done pulse (val=mem_addr, len=cycle number)
  typedef struct {
    int kind;
    int val;
    int len;
  } item_t;
  item_t exp_q[$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_item(input int kind, input int val, input int len);
    item_t it;
    it.kind = kind;
    it.val  = val;
    it.len  = len;
    exp_q.push_back(it);
  endtask

  // Expected events of a complete presentation started in cycle s.
  task automatic push_run(input int lim, input int s);
    for (int i = 0; i <= lim; i++) begin
      push_item(0, 1 << (i % 4), ON);
      if (GAP_EN) push_item(1, 0, OFF);
    end
    push_item(2, lim, s + PER_ENTRY * (lim + 1) + 1);
  endtask

  task automatic emit(input int kind, input int val, input int len);
    item_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: kind=%0d val=%0d len=%0d, nothing expected", kind, val, len);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk((e.kind == 2) ? "done_addr" : "event_value", val, e.val);
      chk((e.kind == 2) ? "done_cycle" : "event_length", len, e.len);
    end
  endtask

  // Monitor: turns the DUT's display activity into events.
  int prev_st = 0;
  int run_len = 0;
  int run_val = 0;
  bit run_ok  = 1'b1;
  int gap_len = 0;
  bit gap_ok  = 1'b1;
  always @(negedge clock) begin
    if (!mon_en || reset) begin
      prev_st = 0;
    end else begin
      if (db_state == 3'd3) begin
        if (prev_st != 3) begin
          run_len = 1;
          run_val = leds;
          run_ok  = 1'b1;
        end else begin
          run_len++;
          if (leds != 4'(run_val)) run_ok = 1'b0;
        end
      end
      if (prev_st == 3 && db_state != 3'd3) emit(0, run_ok ? run_val : -1, run_len);
      if (db_state == 3'd4) begin
        if (prev_st != 4) begin
          gap_len = 1;
          gap_ok  = (leds == 4'd0);
        end else begin
          gap_len++;
          if (leds != 4'd0) gap_ok = 1'b0;
        end
      end
      if (prev_st == 4 && db_state != 3'd4) emit(1, gap_ok ? 0 : -1, gap_len);
      if (done) emit(2, int'(mem_addr), cyc);
      if (!busy) chk("idle_leds", int'(leds), 0);
      prev_st = int'(db_state);
    end
  end

  // Waits for the presentation to end; optional start/limit noise while busy.
  task automatic wait_idle(input int lim, input bit noise);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (noise && busy) begin
        start = 1'($urandom_range(0, 1));
        limit = 4'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
    end while (busy && n < PER_ENTRY * (lim + 1) + 10);
    start = 1'b0;
    if (busy) chk("run_timeout", 1, 0);
    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic run_one(input int lim, input bit noise);
    @(negedge clock);
    limit = 4'(lim);
    start = 1'b1;
    push_run(lim, cyc);
    wait_idle(lim, noise);
  endtask

  // Waits (bounded) until the DUT reaches a given state with a given address.
  task automatic wait_state(input int st, input int addr, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < 200 && !ok) begin
      @(negedge clock);
      n++;
      if (int'(db_state) == st && int'(mem_addr) == addr) ok = 1'b1;
    end
    if (!ok) chk("state_wait_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit ok;
    int s;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    limit = 4'd0;
    repeat (2) @(negedge clock);
    chk("rst_leds", int'(leds), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_state", int'(db_state), 0);
    chk("rst_addr", int'(mem_addr), 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // basic presentation and full-length run
    run_one(3, 1'b0);
    run_one(15, 1'b0);
    chk("addr_no_wrap", int'(mem_addr), 15);

    // start together with abort in IDLE is refused
    @(negedge clock);
    start = 1'b1;
    abort = 1'b1;
    limit = 4'd2;
    @(posedge clock);
    #1;
    chk("start_abort_state", int'(db_state), 0);
    chk("start_abort_busy", int'(busy), 0);
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    repeat (5) @(negedge clock);
    chk("start_abort_quiet", exp_q.size(), 0);

    // abort in the first cycle of the second entry's SHOW
    @(negedge clock);
    limit = 4'd3;
    start = 1'b1;
    push_item(0, 1, ON);
    if (GAP_EN) push_item(1, 0, OFF);
    push_item(0, 2, 1);
    @(negedge clock);
    start = 1'b0;
    wait_state(3, 1, ok);
    abort = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_state", int'(db_state), 0);
    chk("abort_leds", int'(leds), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_addr", int'(mem_addr), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clock);
    abort = 1'b0;
    repeat (8) @(negedge clock);
    chk("abort_queue", exp_q.size(), 0);

    // randomized presentations, some with start/limit noise while busy
    for (int k = 0; k < 6; k++) begin
      run_one($urandom_range(0, 15), 1'($urandom_range(0, 1)));
    end
    run_one(15, 1'b1);

    // asynchronous reset in the middle of the second entry
    mon_en = 1'b0;
    @(negedge clock);
    limit = 4'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_state(GAP_EN ? 4 : 3, 1, ok);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_leds", int'(leds), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_state", int'(db_state), 0);
    chk("arst_addr", int'(mem_addr), 0);
    @(negedge clock);
    reset = 1'b0;
    limit = 4'd0;
    start = 1'b1;
    s = cyc;
    mon_en = 1'b1;
    push_run(0, s);
    wait_idle(0, 1'b0);

    chk("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
